// File: rtl/spatz_simd_lane_sequencer.sv
// Element-group sequencer for one combinational SIMD lane.
// Feeds operands group by group and buffers each lane result under backpressure.
package spatz_simd_lane_pkg;
    typedef enum logic [2:0] {
        VADD, VSUB, VAND, VOR, VXOR, VMUL, VMACC, VMIN
    } op_e;
    typedef enum logic [1:0] {
        EW_8, EW_16, EW_32, EW_64
    } vew_e;
endpackage

module spatz_simd_lane_sequencer
    import spatz_simd_lane_pkg::*;
#(
    parameter int Width   = 32,
    parameter int MaxVl   = 256,
    parameter int VlWidth = $clog2(MaxVl + 1),
    parameter int IdWidth = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  op_e                issue_op_i,
    input  logic [VlWidth-1:0] issue_vl_i,
    input  vew_e               issue_sew_i,
    input  logic               issue_signed_i,
    input  logic [IdWidth-1:0] issue_id_i,
    output logic               opd_req_o,
    output logic [VlWidth-1:0] opd_idx_o,
    input  logic               opd_valid_i,
    input  logic [Width-1:0]   opd_s1_i,
    input  logic [Width-1:0]   opd_s2_i,
    input  logic [Width-1:0]   opd_d_i,
    output op_e                lane_op_o,
    output logic               lane_valid_o,
    output logic [Width-1:0]   lane_s1_o,
    output logic [Width-1:0]   lane_s2_o,
    output logic [Width-1:0]   lane_d_o,
    output logic               lane_signed_o,
    output logic               lane_carry_o,
    output vew_e               lane_sew_o,
    input  logic [Width-1:0]   lane_result_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [Width-1:0]   res_data_o,
    output logic [Width/8-1:0] res_be_o,
    output logic [VlWidth-1:0] res_idx_o,
    output logic               res_last_o,
    output logic               done_o,
    output logic [IdWidth-1:0] done_id_o,
    output logic               busy_o
);
    localparam int NB    = Width / 8;
    localparam int NBLog = $clog2(NB);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, ZERO} state_e;

    state_e             r_state, w_state_nxt;
    op_e                r_op;
    vew_e               r_sew;
    logic               r_signed;
    logic [IdWidth-1:0] r_id;
    logic [VlWidth-1:0] r_vl, r_ng, r_g;
    logic               r_res_valid, r_res_last;
    logic [Width-1:0]   r_res_data;
    logic [NB-1:0]      r_res_be;
    logic [VlWidth-1:0] r_res_idx;

    logic [2:0]         w_ishift, w_rshift;
    logic [VlWidth:0]   w_round;
    logic [VlWidth-1:0] w_issue_ng, w_live;
    logic [VlWidth+2:0] w_live_bytes;
    logic [NB-1:0]      w_be;
    logic               w_last, w_req, w_fire, w_hs, w_done;

    // log2 of elements per group, then ngroups = ceil(vl / epg)
    assign w_ishift   = 3'(NBLog) - {1'b0, issue_sew_i};
    assign w_round    = {1'b0, issue_vl_i}
                      + ((VlWidth+1)'(1) << w_ishift)
                      - (VlWidth+1)'(1);
    assign w_issue_ng = VlWidth'(w_round >> w_ishift);

    assign w_rshift     = 3'(NBLog) - {1'b0, r_sew};
    assign w_last       = (r_g == r_ng - VlWidth'(1));
    assign w_live       = r_vl - VlWidth'(r_g << w_rshift);
    assign w_live_bytes = (VlWidth+3)'(w_live) << r_sew;

    always_comb begin
        w_be = '0;
        for (int b = 0; b < NB; b++) begin
            w_be[b] = !w_last || (w_live_bytes > (VlWidth+3)'(b));
        end
    end

    assign w_hs   = r_res_valid && res_ready_i;
    assign w_req  = (r_state == RUN) && (r_g < r_ng)
                 && (!r_res_valid || res_ready_i);
    assign w_fire = w_req && opd_valid_i;

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (issue_valid_i) begin
                    w_state_nxt = (issue_vl_i == '0) ? ZERO : RUN;
                end
            end
            RUN: begin
                if (w_fire && w_last) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_hs && r_res_last) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            ZERO: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_op        <= VADD;
            r_sew       <= EW_8;
            r_signed    <= 1'b0;
            r_id        <= '0;
            r_vl        <= '0;
            r_ng        <= '0;
            r_g         <= '0;
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
            r_res_data  <= '0;
            r_res_be    <= '0;
            r_res_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && issue_valid_i) begin
                r_op     <= issue_op_i;
                r_sew    <= issue_sew_i;
                r_signed <= issue_signed_i;
                r_id     <= issue_id_i;
                r_vl     <= issue_vl_i;
                r_ng     <= w_issue_ng;
                r_g      <= '0;
            end
            if (w_fire) begin
                r_g        <= r_g + VlWidth'(1);
                r_res_data <= lane_result_i;
                r_res_be   <= w_be;
                r_res_idx  <= r_g;
                r_res_last <= w_last;
            end
            // a capture overrides a drain of the buffer: full throughput
            if (w_fire) begin
                r_res_valid <= 1'b1;
            end else if (w_hs) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign issue_ready_o = (r_state == IDLE);
    assign busy_o        = (r_state != IDLE);
    assign opd_req_o     = w_req;
    assign opd_idx_o     = r_g;
    assign lane_valid_o  = w_fire;
    assign lane_op_o     = r_op;
    assign lane_sew_o    = r_sew;
    assign lane_signed_o = r_signed;
    assign lane_carry_o  = 1'b0;
    assign lane_s1_o     = opd_s1_i;
    assign lane_s2_o     = opd_s2_i;
    assign lane_d_o      = opd_d_i;
    assign res_valid_o   = r_res_valid;
    assign res_data_o    = r_res_data;
    assign res_be_o      = r_res_be;
    assign res_idx_o     = r_res_idx;
    assign res_last_o    = r_res_last;
    assign done_o        = w_done;
    assign done_id_o     = w_done ? r_id : '0;

endmodule

// File: tb/tb_spatz_simd_lane_sequencer.sv
// Randomized scoreboard bench for spatz_simd_lane_sequencer.
// The bench also plays the combinational lane and the VRF/writeback ports.
module tb_spatz_simd_lane_sequencer;
    import spatz_simd_lane_pkg::*;

    localparam int W   = 32;
    localparam int VLW = 9;
    localparam int IDW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_ni = 1'b0;
    logic           issue_valid_i = 1'b0;
    op_e            issue_op_i = VADD;
    logic [VLW-1:0] issue_vl_i = '0;
    vew_e           issue_sew_i = EW_8;
    logic           issue_signed_i = 1'b0;
    logic [IDW-1:0] issue_id_i = '0;
    logic           issue_ready_o, opd_req_o;
    logic [VLW-1:0] opd_idx_o;
    logic           opd_valid_i = 1'b0;
    logic [W-1:0]   opd_s1_i = '0, opd_s2_i = '0, opd_d_i = '0;
    op_e            lane_op_o;
    logic           lane_valid_o, lane_signed_o, lane_carry_o;
    logic [W-1:0]   lane_s1_o, lane_s2_o, lane_d_o, lane_result_i;
    vew_e           lane_sew_o;
    logic           res_valid_o, res_last_o, done_o, busy_o;
    logic           res_ready_i = 1'b0;
    logic [W-1:0]   res_data_o;
    logic [W/8-1:0] res_be_o;
    logic [VLW-1:0] res_idx_o;
    logic [IDW-1:0] done_id_o;

    spatz_simd_lane_sequencer #(.Width(W), .MaxVl(256), .IdWidth(IDW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_op_i(issue_op_i), .issue_vl_i(issue_vl_i),
        .issue_sew_i(issue_sew_i), .issue_signed_i(issue_signed_i),
        .issue_id_i(issue_id_i),
        .opd_req_o(opd_req_o), .opd_idx_o(opd_idx_o),
        .opd_valid_i(opd_valid_i), .opd_s1_i(opd_s1_i),
        .opd_s2_i(opd_s2_i), .opd_d_i(opd_d_i),
        .lane_op_o(lane_op_o), .lane_valid_o(lane_valid_o),
        .lane_s1_o(lane_s1_o), .lane_s2_o(lane_s2_o), .lane_d_o(lane_d_o),
        .lane_signed_o(lane_signed_o), .lane_carry_o(lane_carry_o),
        .lane_sew_o(lane_sew_o), .lane_result_i(lane_result_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_data_o(res_data_o), .res_be_o(res_be_o),
        .res_idx_o(res_idx_o), .res_last_o(res_last_o),
        .done_o(done_o), .done_id_o(done_id_o), .busy_o(busy_o)
    );

    // Element-wise lane behaviour (vd = vs2 op vs1 style)
    function automatic logic [W-1:0] lane_fn(op_e op, vew_e sew, logic sgn,
                                             logic [W-1:0] a, logic [W-1:0] b,
                                             logic [W-1:0] d);
        int bits, n;
        logic [63:0] m, x, y, z, o;
        longint sx, sy;
        logic [W-1:0] r;
        bits = 8 << sew;
        n = W / bits;
        m = (64'd1 << bits) - 64'd1;
        r = '0;
        for (int e = 0; e < n; e++) begin
            x = (64'(a) >> (e * bits)) & m;
            y = (64'(b) >> (e * bits)) & m;
            z = (64'(d) >> (e * bits)) & m;
            case (op)
                VADD:  o = x + y;
                VSUB:  o = y - x;
                VAND:  o = x & y;
                VOR:   o = x | y;
                VXOR:  o = x ^ y;
                VMUL:  o = x * y;
                VMACC: o = z + x * y;
                default: begin
                    sx = longint'(x);
                    sy = longint'(y);
                    if (sgn && x[bits-1]) sx = sx - (longint'(1) << bits);
                    if (sgn && y[bits-1]) sy = sy - (longint'(1) << bits);
                    o = (sx < sy) ? x : y;
                end
            endcase
            r = r | W'((o & m) << (e * bits));
        end
        return r;
    endfunction

    always_comb lane_result_i = lane_fn(lane_op_o, lane_sew_o, lane_signed_o,
                                        lane_s1_o, lane_s2_o, lane_d_o);

    // Stimulus knobs (written by the main process only)
    int          rdy_pct = 100, vld_pct = 100;
    bit          fix_ops = 0, bp_mode = 0, st_mode = 0;
    logic [W-1:0] fs1 = '0, fs2 = '0, fd = '0;
    int          wd_req = 0, wd_exp = 0;

    // Operand / writeback driver
    bit bp_used = 0, st_used = 0;
    int bp_left = 0, st_left = 0;
    always @(posedge clk) begin
        #1;
        res_ready_i = ($urandom_range(99) < rdy_pct);
        opd_valid_i = ($urandom_range(99) < vld_pct);
        if (fix_ops) begin
            opd_s1_i = fs1; opd_s2_i = fs2; opd_d_i = fd;
        end else begin
            opd_s1_i = $urandom; opd_s2_i = $urandom; opd_d_i = $urandom;
        end
        if (!bp_mode) bp_used = 0;
        else if (!bp_used && res_valid_o) begin bp_used = 1; bp_left = 3; end
        if (bp_left > 0) begin res_ready_i = 1'b0; bp_left--; end
        if (!st_mode) st_used = 0;
        else if (!st_used && busy_o && opd_idx_o == 1) begin
            st_used = 1; st_left = 2;
        end
        if (st_left > 0) begin opd_valid_i = 1'b0; st_left--; end
    end

    // Scoreboard, reference model and monitor
    typedef struct {
        logic [W-1:0]   data;
        logic [W/8-1:0] be;
        int             idx;
        bit             last;
    } exp_t;
    exp_t q[$];

    int n_chk = 0, n_fail = 0, done_cnt = 0, wd_ack = 0;
    op_e m_op = VADD;
    vew_e m_sew = EW_8;
    logic m_sgn = 1'b0;
    logic [IDW-1:0] m_id = '0;
    int m_vl = 0, m_ng = 0, m_g = 0;
    bit m_busy = 0, m_active = 0, zero_pend = 0;
    bit hold = 0;
    logic [W-1:0] p_data;
    logic [W/8-1:0] p_be;
    logic [VLW-1:0] p_idx;
    logic p_last;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        bit exp_req, exp_done, acc;
        int epg, bytes;
        if (!rst_ni) begin
            chk("rst_issue_ready", issue_ready_o, 1);
            chk("rst_busy", busy_o, 0);
            chk("rst_opd_req", opd_req_o, 0);
            chk("rst_opd_idx", opd_idx_o, 0);
            chk("rst_lane_valid", lane_valid_o, 0);
            chk("rst_lane_op", lane_op_o, VADD);
            chk("rst_lane_sew", lane_sew_o, 0);
            chk("rst_lane_signed", lane_signed_o, 0);
            chk("rst_res_valid", res_valid_o, 0);
            chk("rst_res_data", res_data_o, 0);
            chk("rst_res_be", res_be_o, 0);
            chk("rst_res_idx", res_idx_o, 0);
            chk("rst_res_last", res_last_o, 0);
            chk("rst_done", done_o, 0);
            chk("rst_done_id", done_id_o, 0);
            q.delete();
            m_busy = 0; m_active = 0; zero_pend = 0; hold = 0;
        end else begin
            exp_req  = m_active && (m_g < m_ng) && (q.size() == 0 || res_ready_i);
            exp_done = zero_pend;
            chk("issue_ready", issue_ready_o, !m_busy);
            chk("busy", busy_o, m_busy);
            chk("res_valid", res_valid_o, q.size() != 0);
            chk("opd_req", opd_req_o, exp_req);
            chk("lane_valid", lane_valid_o, exp_req && opd_valid_i);
            chk("lane_carry", lane_carry_o, 0);
            if (exp_req) chk("opd_idx", opd_idx_o, m_g);
            if (m_busy) begin
                chk("lane_op", lane_op_o, m_op);
                chk("lane_sew", lane_sew_o, m_sew);
                chk("lane_signed", lane_signed_o, m_sgn);
            end
            if (hold) begin
                chk("hold_data", res_data_o, p_data);
                chk("hold_be", res_be_o, p_be);
                chk("hold_idx", res_idx_o, p_idx);
                chk("hold_last", res_last_o, p_last);
            end
            if (q.size() != 0 && res_ready_i) begin
                e = q.pop_front();
                chk("res_data", res_data_o, e.data);
                chk("res_be", res_be_o, e.be);
                chk("res_idx", res_idx_o, e.idx);
                chk("res_last", res_last_o, e.last);
                exp_done = e.last;
            end
            chk("done", done_o, exp_done);
            if (exp_done) chk("done_id", done_id_o, m_id);
            hold   = res_valid_o && !res_ready_i;
            p_data = res_data_o; p_be = res_be_o;
            p_idx  = res_idx_o;  p_last = res_last_o;
            acc = !m_busy && issue_valid_i;
            if (exp_done) begin
                m_busy = 0; zero_pend = 0; done_cnt++;
            end
            if (exp_req && opd_valid_i) begin
                epg = 4 >> m_sew;
                e.data = lane_fn(m_op, m_sew, m_sgn, opd_s1_i, opd_s2_i, opd_d_i);
                e.idx  = m_g;
                e.last = (m_g == m_ng - 1);
                bytes  = (m_vl - m_g * epg) * (1 << m_sew);
                e.be   = e.last ? 4'((1 << bytes) - 1) : 4'hF;
                q.push_back(e);
                m_g++;
                if (m_g == m_ng) m_active = 0;
            end
            if (acc) begin
                m_op = issue_op_i; m_sew = issue_sew_i;
                m_sgn = issue_signed_i; m_id = issue_id_i;
                m_vl = int'(issue_vl_i);
                epg = 4 >> issue_sew_i;
                m_ng = (m_vl + epg - 1) / epg;
                m_g = 0;
                m_busy = 1;
                m_active = (m_vl != 0);
                zero_pend = (m_vl == 0);
            end
        end
        if (wd_req != wd_ack) begin
            chk("watchdog_done_cnt", done_cnt, wd_exp);
            wd_ack = wd_req;
        end
    end

    task automatic pulse_reset();
        @(posedge clk); #3;
        rst_ni = 1'b0;
        @(posedge clk); #3;
        rst_ni = 1'b1;
    endtask

    task automatic issue(op_e op, vew_e sew, int vl, logic sgn, int id);
        @(posedge clk); #1;
        issue_valid_i = 1'b1; issue_op_i = op; issue_sew_i = sew;
        issue_vl_i = VLW'(vl); issue_signed_i = sgn; issue_id_i = IDW'(id);
        @(posedge clk); #1;
        issue_valid_i = 1'b0;
    endtask

    task automatic run(op_e op, vew_e sew, int vl, logic sgn, int id);
        int start;
        start = done_cnt;
        issue(op, sew, vl, sgn, id);
        for (int c = 0; c < 4000 && done_cnt == start; c++) @(negedge clk);
        if (done_cnt == start) begin
            wd_exp = start + 1;
            wd_req++;
            @(negedge clk);
            pulse_reset();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3 rst_ni = 1'b1;

        fix_ops = 1; fs1 = 32'h01010101; fs2 = 32'h02020202; fd = '0;
        run(VADD, EW_8, 10, 1'b0, 1);
        fs1 = 32'd3; fs2 = 32'hFFFFFFFF;
        run(VMUL, EW_32, 4, 1'b1, 5);
        fix_ops = 0;

        bp_mode = 1;
        run(VSUB, EW_16, 6, 1'b0, 2);
        bp_mode = 0;

        st_mode = 1;
        run(VADD, EW_8, 16, 1'b0, 3);
        st_mode = 0;

        run(VADD, EW_16, 0, 1'b0, 6);

        issue(VXOR, EW_8, 40, 1'b0, 7);
        for (int c = 0; c < 200 && m_g < 2; c++) @(posedge clk);
        pulse_reset();
        run(VMACC, EW_8, 7, 1'b0, 4);

        rdy_pct = 70; vld_pct = 70;
        for (int i = 0; i < 40; i++) begin
            run(op_e'($urandom_range(7)), vew_e'($urandom_range(2)),
                ($urandom_range(3) == 0) ? $urandom_range(256) : $urandom_range(24),
                1'($urandom_range(1)), $urandom_range(7));
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
